// File: rtl/pll_reset_sequencer.sv
// rtl/pll_reset_sequencer.sv - supervised PLL reset / lock qualification / SoC reset release sequencer
//
// Purpose:
//   Holds the PLL in reset for a power-up period, waits for lock with a
//   timeout and bounded retries, qualifies lock stability, then releases
//   the SoC reset. Re-sequences on loss of lock or on a software request.
//
// Ports:
//   EXT_CLK_50MHz  in   sole clock (50 MHz board clock)
//   BTN_RESET_n    in   asynchronous active-low push-button reset
//   pll_locked     in   PLL lock, asynchronous to EXT_CLK_50MHz
//   sw_reset_req   in   SoC-only reset request while running (EXT_CLK domain)
//   pll_areset     out  active-high PLL reset
//   soc_reset_n    out  active-low SoC reset
//   seq_state      out  current sequencer state (debug / LEDs)
//   fault          out  sticky: lock retries exhausted
//   lock_lost      out  sticky: lock dropped while running

module pll_reset_sequencer #(
  parameter int POR_CYCLES          = 127,
  parameter int LOCK_TIMEOUT_CYCLES = 50000,
  parameter int LOCK_STABLE_CYCLES  = 1024,
  parameter int RST_RELEASE_CYCLES  = 16,
  parameter int MAX_RETRIES         = 3
) (
  input  logic       EXT_CLK_50MHz,
  input  logic       BTN_RESET_n,
  input  logic       pll_locked,
  input  logic       sw_reset_req,
  output logic       pll_areset,
  output logic       soc_reset_n,
  output logic [2:0] seq_state,
  output logic       fault,
  output logic       lock_lost
);

  localparam int MAX_AB  = (POR_CYCLES > LOCK_TIMEOUT_CYCLES) ? POR_CYCLES : LOCK_TIMEOUT_CYCLES;
  localparam int MAX_CD  = (LOCK_STABLE_CYCLES > RST_RELEASE_CYCLES) ? LOCK_STABLE_CYCLES
                                                                     : RST_RELEASE_CYCLES;
  localparam int MAX_CYC = (MAX_AB > MAX_CD) ? MAX_AB : MAX_CD;
  localparam int CNT_W   = (MAX_CYC > 1) ? $clog2(MAX_CYC) : 1;
  localparam int RETRY_W = $clog2(MAX_RETRIES + 1);

  localparam logic [CNT_W-1:0]   POR_LAST   = CNT_W'(POR_CYCLES - 1);
  localparam logic [CNT_W-1:0]   TO_LAST    = CNT_W'(LOCK_TIMEOUT_CYCLES - 1);
  localparam logic [CNT_W-1:0]   STB_LAST   = CNT_W'(LOCK_STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0]   REL_LAST   = CNT_W'(RST_RELEASE_CYCLES - 1);
  localparam logic [RETRY_W-1:0] RETRY_LAST = RETRY_W'(MAX_RETRIES - 1);

  typedef enum logic [2:0] {
    S_POR_HOLD  = 3'd0,
    S_WAIT_LOCK = 3'd1,
    S_STABLE    = 3'd2,
    S_RELEASE   = 3'd3,
    S_RUN       = 3'd4,
    S_FAULT     = 3'd5
  } state_t;

  state_t             state;
  logic [CNT_W-1:0]   cnt;
  logic [RETRY_W-1:0] retry_cnt;
  logic               lock_meta;
  logic               locked_s;

  assign seq_state = state;

  // Two-flop synchroniser: the FSM only ever looks at locked_s.
  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) begin
      lock_meta <= 1'b0;
      locked_s  <= 1'b0;
    end else begin
      lock_meta <= pll_locked;
      locked_s  <= lock_meta;
    end
  end

  // Outputs are assigned on the same edge as the state change so they are
  // plain flops that always agree with seq_state.
  always_ff @(posedge EXT_CLK_50MHz or negedge BTN_RESET_n) begin
    if (!BTN_RESET_n) begin
      state       <= S_POR_HOLD;
      cnt         <= '0;
      retry_cnt   <= '0;
      pll_areset  <= 1'b1;
      soc_reset_n <= 1'b0;
      fault       <= 1'b0;
      lock_lost   <= 1'b0;
    end else begin
      cnt <= cnt + 1'b1;
      case (state)
        S_POR_HOLD: begin
          if (cnt == POR_LAST) begin
            state      <= S_WAIT_LOCK;
            cnt        <= '0;
            pll_areset <= 1'b0;
          end
        end
        S_WAIT_LOCK: begin
          if (locked_s) begin
            state <= S_STABLE;
            cnt   <= '0;
          end else if (cnt == TO_LAST) begin
            cnt        <= '0;
            retry_cnt  <= retry_cnt + 1'b1;
            pll_areset <= 1'b1;
            if (retry_cnt == RETRY_LAST) begin
              state <= S_FAULT;
              fault <= 1'b1;
            end else begin
              state <= S_POR_HOLD;
            end
          end
        end
        S_STABLE: begin
          // A dropout restarts qualification but is not a timeout, so no retry.
          if (!locked_s) begin
            state <= S_WAIT_LOCK;
            cnt   <= '0;
          end else if (cnt == STB_LAST) begin
            state <= S_RELEASE;
            cnt   <= '0;
          end
        end
        S_RELEASE: begin
          if (!locked_s) begin
            state      <= S_POR_HOLD;
            cnt        <= '0;
            pll_areset <= 1'b1;
          end else if (cnt == REL_LAST) begin
            cnt <= '0;
            // A still-asserted request restarts the hold instead of giving
            // the SoC a one-cycle release pulse.
            if (!sw_reset_req) begin
              state       <= S_RUN;
              soc_reset_n <= 1'b1;
              retry_cnt   <= '0;
            end
          end
        end
        S_RUN: begin
          cnt <= '0;
          // Lock loss takes priority over a simultaneous software request.
          if (!locked_s) begin
            state       <= S_POR_HOLD;
            pll_areset  <= 1'b1;
            soc_reset_n <= 1'b0;
            lock_lost   <= 1'b1;
          end else if (sw_reset_req) begin
            state       <= S_RELEASE;
            soc_reset_n <= 1'b0;
          end
        end
        S_FAULT: begin
          cnt         <= '0;
          pll_areset  <= 1'b1;
          soc_reset_n <= 1'b0;
          fault       <= 1'b1;
        end
        default: begin
          state       <= S_POR_HOLD;
          cnt         <= '0;
          pll_areset  <= 1'b1;
          soc_reset_n <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_pll_reset_sequencer.sv
// tb/tb_pll_reset_sequencer.sv - self-checking bench for pll_reset_sequencer

module tb_pll_reset_sequencer;

  localparam int P   = 8;
  localparam int T   = 32;
  localparam int STB = 16;
  localparam int REL = 4;
  localparam int MR  = 2;
  localparam int F   = MR * (P + T);

  logic       EXT_CLK_50MHz = 1'b0;
  logic       BTN_RESET_n   = 1'b0;
  logic       pll_locked    = 1'b0;
  logic       sw_reset_req  = 1'b0;
  logic       pll_areset;
  logic       soc_reset_n;
  logic [2:0] seq_state;
  logic       fault;
  logic       lock_lost;

  pll_reset_sequencer #(
    .POR_CYCLES(P), .LOCK_TIMEOUT_CYCLES(T), .LOCK_STABLE_CYCLES(STB),
    .RST_RELEASE_CYCLES(REL), .MAX_RETRIES(MR)
  ) dut (
    .EXT_CLK_50MHz(EXT_CLK_50MHz), .BTN_RESET_n(BTN_RESET_n), .pll_locked(pll_locked),
    .sw_reset_req(sw_reset_req), .pll_areset(pll_areset), .soc_reset_n(soc_reset_n),
    .seq_state(seq_state), .fault(fault), .lock_lost(lock_lost)
  );

  always #10 EXT_CLK_50MHz = ~EXT_CLK_50MHz;

  int   n_pass  = 0;
  int   n_total = 0;
  int   seg_at[$];
  int   seg_st[$];
  int   lost_from;
  logic lock_wave [0:255];
  logic sw_wave   [0:255];
  logic btn_wave  [0:255];

  // Expected timeline as a list of (first sample, state) segments.
  function automatic int exp_state(int n);
    int st = 0;
    foreach (seg_at[i]) if (seg_at[i] <= n) st = seg_st[i];
    return st;
  endfunction

  // First edge at which WAIT_LOCK sees lock, for a sequence whose POR_HOLD
  // begins at edge 'base' and whose lock input rose at sample 'l'
  // (synchronised lock is visible to the edge l+3). -1 means retries run out.
  function automatic int lock_edge(int base, int l);
    for (int a = 0; a < MR; a++) begin
      int s    = base + (a + 1) * P + a * T + 1;
      int cand = (l + 3 > s) ? l + 3 : s;
      if (cand <= s + T - 1) return cand;
    end
    return -1;
  endfunction

  task automatic clear_scn();
    seg_at.delete();
    seg_st.delete();
    lost_from = -1;
    for (int i = 0; i < 256; i++) begin
      lock_wave[i] = 1'b0;
      sw_wave[i]   = 1'b0;
      btn_wave[i]  = 1'b1;
    end
  endtask

  task automatic seg(input int at, input int st);
    seg_at.push_back(at);
    seg_st.push_back(st);
  endtask

  task automatic set_lock(input int from, input int to, input logic v);
    for (int i = from; i <= to && i < 256; i++) lock_wave[i] = v;
  endtask

  // Segments for the power-up attempts before lock (or the fault) at edge e.
  task automatic bringup_segs(input int e);
    for (int a = 0; a < MR; a++) begin
      if (e < 0 || a * (P + T) < e)     seg(a * (P + T), 0);
      if (e < 0 || a * (P + T) + P < e) seg(a * (P + T) + P, 1);
    end
    if (e < 0) seg(F, 5);
    else begin
      seg(e, 2);
      seg(e + STB, 3);
      seg(e + STB + REL, 4);
    end
  endtask

  task automatic run_trace(input string tag, input int nlast);
    logic [6:0] obs, expv;
    int st;
    BTN_RESET_n  = 1'b0;
    pll_locked   = 1'b0;
    sw_reset_req = 1'b0;
    repeat (2) @(posedge EXT_CLK_50MHz);
    for (int n = 0; n <= nlast; n++) begin
      @(negedge EXT_CLK_50MHz);
      st   = exp_state(n);
      expv = {3'(st), (st == 0 || st == 5), (st == 4), (st == 5),
              (lost_from >= 0 && n >= lost_from)};
      obs  = {seq_state, pll_areset, soc_reset_n, fault, lock_lost};
      n_total++;
      assert (obs === expv) n_pass++;
      else $error("FAIL %s sample %0d: {state,areset,soc_rst_n,fault,lost} observed %b expected %b",
                  tag, n, obs, expv);
      BTN_RESET_n  = btn_wave[n];
      pll_locked   = lock_wave[n];
      sw_reset_req = sw_wave[n];
    end
  endtask

  initial begin
    int e, e2, g, len, G, D, Rl, k, H, j, B, Q;
    int lt[$];

    // Power-up with lock rising at various times, including never.
    lt = '{20, 0, 200, 40};
    repeat (4) lt.push_back($urandom_range(0, 85));
    foreach (lt[i]) begin
      clear_scn();
      set_lock(lt[i], 255, 1'b1);
      e = lock_edge(0, lt[i]);
      bringup_segs(e);
      run_trace($sformatf("powerup_L%0d", lt[i]), (e < 0) ? F + 10 : e + STB + REL + 8);
    end

    // Lock dropout during STABLE: back to WAIT_LOCK, full requalification.
    for (int it = 0; it < 4; it++) begin
      g   = (it == 0) ? 10 : $urandom_range(0, 13);
      len = (it == 0) ? 3 : $urandom_range(1, 3);
      clear_scn();
      set_lock(20, 255, 1'b1);
      G = 23 + g;
      set_lock(G, G + len - 1, 1'b0);
      seg(0, 0); seg(P, 1); seg(23, 2); seg(G + 3, 1);
      e2 = G + len + 3;
      seg(e2, 2); seg(e2 + STB, 3); seg(e2 + STB + REL, 4);
      run_trace($sformatf("glitch_g%0d_len%0d", g, len), e2 + STB + REL + 5);
    end

    // Lock in second attempt, dropout in STABLE, never returns: the dropout
    // does not consume a retry, so the next timeout is the final one.
    clear_scn();
    set_lock(45, 54, 1'b1);
    e = lock_edge(0, 45);
    bringup_segs(e);
    seg_at.delete(); seg_st.delete();
    seg(0, 0); seg(P, 1); seg(P + T, 0); seg(2 * P + T, 1); seg(e, 2);
    seg(58, 1); seg(58 + T, 5);
    run_trace("glitch_then_timeout", 100);

    // Lock lost while running, relocks during the new POR hold.
    for (int it = 0; it < 3; it++) begin
      D  = $urandom_range(30, 40);
      Rl = D + $urandom_range(1, 14);
      clear_scn();
      set_lock(0, D - 1, 1'b1);
      set_lock(Rl, 255, 1'b1);
      bringup_segs(lock_edge(0, 0));
      B = D + 3;
      lost_from = B;
      seg(B, 0); seg(B + P, 1);
      e2 = lock_edge(B, Rl);
      seg(e2, 2); seg(e2 + STB, 3); seg(e2 + STB + REL, 4);
      run_trace($sformatf("run_lock_drop_D%0d_R%0d", D, Rl), e2 + STB + REL + 5);
    end

    // Software reset request while running: pulse first, then held levels.
    for (int it = 0; it < 4; it++) begin
      k = $urandom_range(30, 40);
      H = (it == 0) ? 1 : $urandom_range(2, 12);
      clear_scn();
      set_lock(0, 255, 1'b1);
      for (int i = k; i < k + H; i++) sw_wave[i] = 1'b1;
      bringup_segs(lock_edge(0, 0));
      j = (H + REL - 1) / REL;
      if (j < 1) j = 1;
      seg(k + 1, 3); seg(k + 1 + REL * j, 4);
      run_trace($sformatf("sw_req_k%0d_H%0d", k, H), k + 1 + REL * j + 6);
    end

    // Request and lock loss on the same edge; retry count was cleared on RUN
    // entry, so a full two-attempt sequence precedes the fault.
    clear_scn();
    set_lock(30, 74, 1'b1);
    sw_wave[77] = 1'b1;
    bringup_segs(lock_edge(0, 30));
    B = 78;
    lost_from = B;
    seg(B, 0); seg(B + P, 1); seg(B + P + T, 0); seg(B + 2 * P + T, 1); seg(B + F, 5);
    run_trace("sw_and_lock_loss", B + F + 6);

    // Push-button reset in the middle of STABLE.
    clear_scn();
    set_lock(20, 255, 1'b1);
    btn_wave[30] = 1'b0; btn_wave[31] = 1'b0; btn_wave[32] = 1'b0;
    Q = 33;
    seg(0, 0); seg(P, 1); seg(23, 2); seg(31, 0); seg(Q + P, 1);
    e2 = lock_edge(Q, Q);
    seg(e2, 2); seg(e2 + STB, 3); seg(e2 + STB + REL, 4);
    run_trace("btn_mid_stable", e2 + STB + REL + 5);

    // Push-button reset clears a fault; clean sequence afterwards.
    clear_scn();
    btn_wave[85] = 1'b0; btn_wave[86] = 1'b0; btn_wave[87] = 1'b0;
    Q = 88;
    set_lock(Q, 255, 1'b1);
    bringup_segs(-1);
    seg(86, 0); seg(Q + P, 1);
    e2 = lock_edge(Q, Q);
    seg(e2, 2); seg(e2 + STB, 3); seg(e2 + STB + REL, 4);
    run_trace("btn_clears_fault", e2 + STB + REL + 5);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
